debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Parametrised N-channel push-button conditioner for board-level inputs.
//  Per channel: N-stage synchroniser, stable-time filter, debounced level, one-cycle press/release strobes.
//  Optional per-channel auto-repeat while a button is held (hold-to-increment).
//  Sits between raw pad inputs and the control FSMs; all outputs are synchronous to clk_i.
// PARAMETERS
//  N_CH           4      number of independent button channels
//  SYNC_STAGES    2      flip-flop synchroniser depth, >=2
//  STABLE_CYCLES  50000  consecutive cycles an input must differ from the level before the level flips, >=1
//  REPEAT_DELAY   25000000  cycles from press_o to the first repeat_o, >=1
//  REPEAT_PERIOD  5000000   cycles between later repeat_o pulses, >=1
//  CNT_W          derived   $clog2(STABLE_CYCLES+1); RPT_W = $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)
// PORTS
//  clk_i          in   1     system clock
//  reset_i        in   1     asynchronous, active-low reset
//  buttonin_i     in   N_CH  raw asynchronous button levels, 1 = pressed
//  repeat_en_i    in   N_CH  per-channel auto-repeat enable, synchronous
//  level_o        out  N_CH  debounced level
//  press_o        out  N_CH  1-cycle strobe on debounced 0->1
//  release_o      out  N_CH  1-cycle strobe on debounced 1->0
//  repeat_o       out  N_CH  1-cycle auto-repeat strobe while held
//  event_o        out  N_CH  press_o | repeat_o (single "increment" strobe)
// BEHAVIOUR
//  Reset (reset_i=0, async): sync chain, level_o, all strobes, all counters = 0. Takes effect mid-filter or
//   mid-hold with no pulse emitted; after release of reset a held button must re-qualify fully.
//  Sync: s = last stage of SYNC_STAGES flops on buttonin_i[ch]. All decisions use s only.
//  Filter, per channel, per edge:
//   s==level: cnt<=0.
//   s!=level, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
//   s!=level, cnt==STABLE_CYCLES-1: level<=s, cnt<=0, press_o (s=1) or release_o (s=0) high for exactly that cycle.
//   A single cycle of s==level anywhere in the window restarts qualification (glitch rejection).
//  Latency: raw step held steady -> level_o and strobe change SYNC_STAGES+STABLE_CYCLES edges later.
//  Strobes are registered; press_o and release_o are never high together on one channel.
//  Repeat, per channel: rpt counter, first flag.
//   press_o edge: rpt<=0, first<=1.
//   level=1 & repeat_en_i=1: rpt increments; when rpt reaches (first ? REPEAT_DELAY : REPEAT_PERIOD)-1:
//    repeat_o pulses 1 cycle, rpt<=0, first<=0.
//   level=1 & repeat_en_i=0: rpt<=0, first<=1, no repeat_o; re-enable restarts the full REPEAT_DELAY.
//   level=0: rpt<=0, first<=1, repeat_o=0. Release wins over any coincident repeat terminal count.
//  repeat_o is never coincident with press_o. STABLE_CYCLES=1 is legal: one-cycle filter.
//  Counters saturate by construction; no wrap-around is possible in any state.
//  Channels are fully independent; simultaneous events on different channels are all reported that cycle.
// STRUCTURE
//  Sub-module debounce_channel: one sync chain, filter and repeat logic; debounce_bank is a generate loop of N_CH.
//  Shared package debounce_pkg: default STABLE_CYCLES/REPEAT_* constants for the 100 MHz board clock, clog2 helper,
//   parameter-legality checks (elaboration error if any parameter < 1 or SYNC_STAGES < 2).
//  No FSM enum is needed beyond the first flag; the level bit is the filter state.
// TESTING  (N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  Clean press ch0 at edge 0, held -> level_o[0]=1 and press_o[0]=1 at edge 10 only; ch1..3 stay 0.
//  ch1 bounces 1,0,1,0 every 3 cycles then holds 1 -> exactly one press_o[1], 10 edges after the final rising edge.
//  ch2 held, repeat_en_i[2]=1 -> press_o at t, repeat_o at t+20, t+25, t+30; release -> release_o 10 edges later, no repeat after.
//  ch3 held, repeat_en_i dropped at t+12, raised at t+15 -> no repeat_o before t+35; first at t+35.
//  reset_i low for 1 cycle while ch0 is 5 cycles into qualification -> no strobe; press_o[0] 10 edges after reset release.
//  Presses on all 4 channels on the same cycle -> press_o=4'b1111 in a single cycle; event_o equals press_o|repeat_o throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, sizing helpers and parameter checks for debounce_bank
package debounce_pkg;

  // Defaults sized for the 100 MHz board clock: 0.5 ms filter, 250 ms first repeat, 50 ms repeat period.
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  function automatic int clog2(input int value);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < longint'(value)) begin
      p = p << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int sync_stages, input int stable_cycles,
                                   input int repeat_delay, input int repeat_period);
    return (sync_stages >= 2) && (stable_cycles >= 1) &&
           (repeat_delay >= 1) && (repeat_period >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, stable-time filter, press/release strobes, auto-repeat
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CNT_W = clog2(STABLE_CYCLES + 1);
  localparam int RPT_W = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  generate
    if (!params_ok(SYNC_STAGES, STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
      $error("debounce_channel: illegal parameter value");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [RPT_W-1:0]       rpt_cnt;
  logic                   first;
  logic                   s;
  logic                   flip;
  logic                   rise;
  logic                   fall;
  logic                   rpt_hit;

  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    flip    = (s != level) && (cnt == CNT_LAST);
    rise    = flip & s;
    fall    = flip & ~s;
    rpt_hit = (rpt_cnt == (first ? DELAY_LAST : PERIOD_LAST));
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q  <= '0;
      level   <= 1'b0;
      cnt     <= '0;
      rpt_cnt <= '0;
      first   <= 1'b1;
      press   <= 1'b0;
      rel     <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      press  <= rise;
      rel    <= fall;
      rpt    <= 1'b0;

      if (s == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A press sees level=0 here, and a release takes priority over a terminal count.
      if (!level || fall || !repeat_en) begin
        rpt_cnt <= '0;
        first   <= 1'b1;
      end else if (rpt_hit) begin
        rpt     <= 1'b1;
        rpt_cnt <= '0;
        first   <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel push-button conditioner, one debounce_channel per button
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] buttonin_i,
  input  logic [N_CH-1:0] repeat_en_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o,
  output logic [N_CH-1:0] event_o
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .button   (buttonin_i[ch]),
      .repeat_en(repeat_en_i[ch]),
      .level    (level_o[ch]),
      .press    (press_o[ch]),
      .rel      (release_o[ch]),
      .rpt      (repeat_o[ch])
    );
  end

  // Press and repeat never coincide on a channel, so the OR is a clean single increment strobe.
  assign event_o = press_o | repeat_o;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - randomized self-checking bench for debounce_bank against a behavioural model
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic         clk;
  logic         reset_i;
  logic [N-1:0] buttonin_i;
  logic [N-1:0] repeat_en_i;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic [N-1:0] repeat_o;
  logic [N-1:0] event_o;

  debounce_bank #(
    .N_CH(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .buttonin_i (buttonin_i),
    .repeat_en_i(repeat_en_i),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .repeat_o   (repeat_o),
    .event_o    (event_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: the synchroniser is a plain delay line of raw samples; the filter counts how long
  // s has disagreed with the level; repeats fall at held = RD, RD+RP, RD+2RP, ...
  bit           pipe [N][SS];
  bit           m_level [N];
  int           run [N];
  int           held [N];
  logic [N-1:0] exp_level, exp_press, exp_rel, exp_rpt;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < SS; i++) pipe[c][i] = 1'b0;
      m_level[c] = 1'b0;
      run[c]     = 0;
      held[c]    = 0;
    end
    exp_level = '0; exp_press = '0; exp_rel = '0; exp_rpt = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit s, old_level, fell;
      s         = pipe[c][SS-1];
      old_level = m_level[c];
      for (int i = SS-1; i > 0; i--) pipe[c][i] = pipe[c][i-1];
      pipe[c][0] = buttonin_i[c];
      exp_press[c] = 1'b0;
      exp_rel[c]   = 1'b0;
      exp_rpt[c]   = 1'b0;
      fell         = 1'b0;
      if (s != old_level) begin
        run[c]++;
        if (run[c] == SC) begin
          m_level[c] = s;
          run[c]     = 0;
          if (s) exp_press[c] = 1'b1;
          else begin exp_rel[c] = 1'b1; fell = 1'b1; end
        end
      end else begin
        run[c] = 0;
      end
      if (!old_level || fell || !repeat_en_i[c]) begin
        held[c] = 0;
      end else begin
        held[c]++;
        exp_rpt[c] = (held[c] == RD) || (held[c] > RD && (held[c] - RD) % RP == 0);
      end
      exp_level[c] = m_level[c];
    end
  endtask

  task automatic compare_all();
    check_eq("level",   32'(level_o),   32'(exp_level));
    check_eq("press",   32'(press_o),   32'(exp_press));
    check_eq("release", 32'(release_o), 32'(exp_rel));
    check_eq("repeat",  32'(repeat_o),  32'(exp_rpt));
    check_eq("event",   32'(event_o),   32'(exp_press | exp_rpt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_i) model_step();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    reset_i = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    reset_i = 1'b1;
  endtask

  int found;
  int rem [N];

  initial begin
    reset_i     = 1'b0;
    buttonin_i  = '0;
    repeat_en_i = '0;
    model_reset();
    tick();
    tick();
    check_eq("reset_level", 32'(level_o), 32'd0);
    check_eq("reset_event", 32'(event_o), 32'd0);
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Clean press on ch0: strobe SS+SC edges after the step.
    buttonin_i[0] = 1'b1;
    found = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (press_o[0] && found == 0) found = i;
    end
    check_eq("press_latency", 32'(found), 32'(SS + SC));
    buttonin_i[0] = 1'b0;
    for (int i = 0; i < 15; i++) tick();

    // All channels pressed together.
    buttonin_i = '1;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick();
      if (press_o != '0) begin
        found = i;
        check_eq("press_all", 32'(press_o), 32'hF);
      end
    end
    check_eq("press_all_latency", 32'(found), 32'(SS + SC));
    buttonin_i = '0;
    for (int i = 0; i < 15; i++) tick();

    // Reset while ch0 is mid-qualification: full re-qualification afterwards.
    buttonin_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pulse_reset();
    found = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (press_o[0] && found == 0) found = i;
    end
    check_eq("press_after_reset", 32'(found), 32'(SS + SC));
    buttonin_i[0] = 1'b0;
    for (int i = 0; i < 15; i++) tick();

    // Auto-repeat on ch2: first repeat RD after press, next RP later.
    repeat_en_i[2] = 1'b1;
    buttonin_i[2]  = 1'b1;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick();
      if (press_o[2]) found = i;
    end
    check_eq("rpt_press_seen", 32'(found != 0), 32'd1);
    found = 0;
    for (int i = 1; i <= 40 && found == 0; i++) begin
      tick();
      if (repeat_o[2]) found = i;
    end
    check_eq("rpt_first_delay", 32'(found), 32'(RD));
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      tick();
      if (repeat_o[2]) found = i;
    end
    check_eq("rpt_period", 32'(found), 32'(RP));
    buttonin_i[2] = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Random bouncing buttons, enables and occasional resets.
    repeat_en_i = '1;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          buttonin_i[c] = ~buttonin_i[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 70);
        end else begin
          rem[c]--;
        end
        if (repeat_en_i[c] && $urandom_range(0, 59) == 0) repeat_en_i[c] = 1'b0;
        else if (!repeat_en_i[c] && $urandom_range(0, 4) == 0) repeat_en_i[c] = 1'b1;
      end
      if ($urandom_range(0, 699) == 0) pulse_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
